// File: rtl/branch_pc_unit.sv
// Next-PC stage of the RV32 single-cycle core: branch resolve, PC register,
// misaligned-target trap FSM and retired/taken branch counters.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic             BrUn,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             br_taken,
    output logic             trap,
    output logic [31:0]      trap_epc,
    output logic [31:0]      trap_addr,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {RUN, TRAP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    logic        cond;
    logic        br_cond;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] jalr_sum;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:          cond = BrEq;
            3'b001:          cond = !BrEq;
            3'b100, 3'b110:  cond = BrLT;
            3'b101, 3'b111:  cond = !BrLT;
            default:         cond = 1'b0;
        endcase
    end

    assign BrUn     = funct3[2] & funct3[1];
    assign br_cond  = is_branch & cond;
    assign jalr_sum = rs1_data + imm;
    assign target   = is_jalr ? {jalr_sum[31:1], 1'b0} : pc_q + imm;
    // No redirect is ever reported while the trap is pending.
    assign redirect = (state_q == RUN) & (is_jalr | is_jal | br_cond);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    if (redirect && target[1]) begin
                        epc_d   = pc_q;
                        addr_d  = target;
                        state_d = TRAP;
                    end else begin
                        pc_d = redirect ? target : pc_q + 32'd4;
                        if (is_branch) begin
                            bcnt_d = bcnt_q + 1'b1;
                            if (cond) tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
            end
            TRAP: begin
                if (trap_ack) begin
                    pc_d    = TRAP_VEC;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            addr_q  <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign br_taken   = redirect;
    assign trap       = (state_q == TRAP);
    assign trap_epc   = epc_q;
    assign trap_addr  = addr_q;
    assign branch_cnt = bcnt_q;
    assign taken_cnt  = tcnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expected values.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic [31:0] imm, rs1_data;
    logic        BrEq, BrLT, BrUn;
    logic [31:0] pc, pc_plus4;
    logic        br_taken, trap;
    logic [31:0] trap_epc, trap_addr;
    logic        trap_ack;
    logic [31:0] branch_cnt, taken_cnt;

    int total = 0;
    int bad = 0;

    branch_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .imm(imm), .rs1_data(rs1_data),
        .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
        .pc(pc), .pc_plus4(pc_plus4), .br_taken(br_taken),
        .trap(trap), .trap_epc(trap_epc), .trap_addr(trap_addr),
        .trap_ack(trap_ack),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
        funct3 = 3'b010; imm = 0; rs1_data = 0;
        BrEq = 0; BrLT = 0; trap_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jal(input logic [31:0] off);
        idle(); is_jal = 1; imm = off;
        #1;
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        #2;
        rst_n = 1;
        #1;
    endtask

    initial begin
        idle();
        #22 rst_n = 1;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_brun", {31'b0, BrUn}, 32'h0);
        chk("rst_bcnt", branch_cnt, 32'h0);
        chk("rst_tcnt", taken_cnt, 32'h0);
        chk("rst_trap", {31'b0, trap}, 32'h0);
        step(); chk("seq4", pc, 32'h4);
        step(); chk("seq8", pc, 32'h8);
        step(); chk("seq12", pc, 32'hC);

        jal(32'h34);
        chk("jal_pc40", pc, 32'h40);
        chk("jal_nocnt", branch_cnt, 32'h0);

        idle(); is_branch = 1; funct3 = 3'b111; imm = 32'h20; BrLT = 0;
        #1;
        chk("bgeu_brun", {31'b0, BrUn}, 32'h1);
        chk("bgeu_taken", {31'b0, br_taken}, 32'h1);
        step();
        chk("bgeu_pc", pc, 32'h60);
        chk("bgeu_bcnt", branch_cnt, 32'h1);
        chk("bgeu_tcnt", taken_cnt, 32'h1);

        idle(); is_branch = 1; funct3 = 3'b001; imm = 32'h20; BrEq = 1;
        #1;
        chk("bne_brun", {31'b0, BrUn}, 32'h0);
        chk("bne_taken", {31'b0, br_taken}, 32'h0);
        step();
        chk("bne_pc", pc, 32'h64);
        chk("bne_bcnt", branch_cnt, 32'h2);
        chk("bne_tcnt", taken_cnt, 32'h1);

        idle(); is_jalr = 1; is_branch = 1; funct3 = 3'b000; BrEq = 1;
        rs1_data = 32'h1001; imm = 32'h0;
        #1;
        chk("jalr_link", pc_plus4, 32'h68);
        chk("jalr_taken", {31'b0, br_taken}, 32'h1);
        step();
        chk("jalr_pc", pc, 32'h1000);
        chk("jalr_notrap", {31'b0, trap}, 32'h0);

        do_reset();
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_bcnt", branch_cnt, 32'h0);
        jal(32'h7C);
        chk("pc7c", pc, 32'h7C);
        idle(); is_branch = 1; funct3 = 3'b000; BrEq = 0; imm = 32'h2;
        #1;
        step();
        chk("nt_mis_pc", pc, 32'h80);
        chk("nt_mis_trap", {31'b0, trap}, 32'h0);
        chk("nt_mis_bcnt", branch_cnt, 32'h1);

        idle(); is_jal = 1; imm = 32'h6;
        #1;
        chk("mis_taken", {31'b0, br_taken}, 32'h1);
        chk("mis_pretrap", {31'b0, trap}, 32'h0);
        step();
        chk("mis_pc", pc, 32'h80);
        chk("mis_trap", {31'b0, trap}, 32'h1);
        chk("mis_epc", trap_epc, 32'h80);
        chk("mis_addr", trap_addr, 32'h86);
        chk("mis_bcnt", branch_cnt, 32'h1);
        chk("mis_tcnt", taken_cnt, 32'h0);
        idle(); is_jal = 1; imm = 32'h10; is_branch = 1;
        funct3 = 3'b000; BrEq = 1;
        #1;
        chk("trap_notaken", {31'b0, br_taken}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("trap_hold_pc", pc, 32'h80);
            chk("trap_hold", {31'b0, trap}, 32'h1);
        end
        chk("trap_hold_bcnt", branch_cnt, 32'h1);
        idle(); trap_ack = 1;
        #1;
        step();
        idle();
        chk("ack_pc", pc, 32'h100);
        chk("ack_trap", {31'b0, trap}, 32'h0);
        chk("ack_epc", trap_epc, 32'h80);

        idle(); stall = 1; is_branch = 1; funct3 = 3'b000; BrEq = 1;
        imm = 32'h40;
        #1;
        chk("stall_taken", {31'b0, br_taken}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_pc", pc, 32'h100);
            chk("stall_bcnt", branch_cnt, 32'h1);
            chk("stall_tcnt", taken_cnt, 32'h0);
        end
        stall = 0;
        step();
        idle();
        chk("unstall_pc", pc, 32'h140);
        chk("unstall_bcnt", branch_cnt, 32'h2);
        chk("unstall_tcnt", taken_cnt, 32'h1);

        jal(32'hFFFF_FEBC);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        chk("p4_wrap", pc_plus4, 32'h0);
        idle();
        step();
        chk("pc_wrap", pc, 32'h0);

        jal(32'h2);
        chk("t2_trap", {31'b0, trap}, 32'h1);
        chk("t2_addr", trap_addr, 32'h2);
        idle();
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("arst_trap", {31'b0, trap}, 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_epc", trap_epc, 32'h0);
        chk("arst_addr", trap_addr, 32'h0);
        chk("arst_bcnt", branch_cnt, 32'h0);
        #2 rst_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
